// File: rtl/panel_mem_sequencer_if.sv
// Signal bundle between the front-panel sequencer and the panel I/O, CPU bus and memory.
// The sequencer takes the slave view; the panel/bus side takes the master view.
interface panel_mem_sequencer_if;
  logic       cpu_halted;
  logic       cmd_deposit;
  logic       cmd_examine;
  logic       cmd_auto_inc;
  logic [7:0] panel_addr;
  logic [7:0] panel_data;
  logic [7:0] data_bus;
  logic [1:0] mux_select;
  logic [7:0] data_bus_injection;
  logic       ar_load;
  logic       memory_cs;
  logic       memory_we;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] examine_data;
  logic [7:0] addr_ptr;

  modport master (
    output cpu_halted, cmd_deposit, cmd_examine, cmd_auto_inc,
    output panel_addr, panel_data, data_bus,
    input  mux_select, data_bus_injection, ar_load, memory_cs, memory_we,
    input  busy, done, error, examine_data, addr_ptr
  );

  modport slave (
    input  cpu_halted, cmd_deposit, cmd_examine, cmd_auto_inc,
    input  panel_addr, panel_data, data_bus,
    output mux_select, data_bus_injection, ar_load, memory_cs, memory_we,
    output busy, done, error, examine_data, addr_ptr
  );
endinterface

// File: rtl/panel_mem_sequencer.sv
// Front-panel deposit/examine sequencer: turns panel command edges into timed AR-load and
// memory CS/WE cycles on the shared CPU bus while the CPU is halted.
module panel_mem_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int WE_CYCLES     = 2,
  parameter int READ_CYCLES   = 2
) (
  input logic                  clk,
  input logic                  reset,
  panel_mem_sequencer_if.slave bus
);

  localparam int MaxAB     = (SETTLE_CYCLES > WE_CYCLES) ? SETTLE_CYCLES : WE_CYCLES;
  localparam int MaxCycles = (MaxAB > READ_CYCLES) ? MaxAB : READ_CYCLES;
  localparam int CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] WeLoad     = CntW'(WE_CYCLES - 1);
  localparam logic [CntW-1:0] ReadLoad   = CntW'(READ_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_ADDR,
    SETTLE,
    WRITE,
    READ,
    FINISH
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      opAddr_q, opAddr_d;
  logic [7:0]      opData_q, opData_d;
  logic            isWrite_q, isWrite_d;
  logic            autoInc_q, autoInc_d;
  logic [7:0]      addrPtr_q, addrPtr_d;
  logic [7:0]      examData_q, examData_d;
  logic            depPrev_q, exaPrev_q;

  logic [1:0]      muxSel_q, muxSel_d;
  logic [7:0]      inj_q, inj_d;
  logic            arLoad_q, arLoad_d;
  logic            cs_q, cs_d;
  logic            we_q, we_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic            depEdge, exaEdge, opActive;

  assign depEdge  = bus.cmd_deposit & ~depPrev_q;
  assign exaEdge  = bus.cmd_examine & ~exaPrev_q;
  assign opActive = (state_q == LOAD_ADDR) || (state_q == SETTLE) ||
                    (state_q == WRITE)     || (state_q == READ);

  // Next-state logic; all bus outputs are then decoded from the next state so they
  // come straight out of flops and line up with the state they belong to.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opAddr_d   = opAddr_q;
    opData_d   = opData_q;
    isWrite_d  = isWrite_q;
    autoInc_d  = autoInc_q;
    addrPtr_d  = addrPtr_q;
    examData_d = examData_q;
    error_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (depEdge || exaEdge) begin
          if (!bus.cpu_halted) begin
            error_d = 1'b1;
          end else begin
            opAddr_d  = bus.cmd_auto_inc ? addrPtr_q : bus.panel_addr;
            opData_d  = bus.panel_data;
            isWrite_d = depEdge;
            autoInc_d = bus.cmd_auto_inc;
            addrPtr_d = opAddr_d;
            state_d   = LOAD_ADDR;
          end
        end
      end
      LOAD_ADDR: begin
        state_d = SETTLE;
        cnt_d   = SettleLoad;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = isWrite_q ? WRITE : READ;
          cnt_d   = isWrite_q ? WeLoad : ReadLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WRITE: begin
        if (cnt_q == '0) begin
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          examData_d = bus.data_bus;
          state_d    = FINISH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
        if (autoInc_q) begin
          addrPtr_d = addrPtr_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Losing the halt mid-cycle abandons the operation; FINISH has already reported done.
    if (opActive && !bus.cpu_halted) begin
      state_d    = IDLE;
      cnt_d      = cnt_q;
      examData_d = examData_q;
      addrPtr_d  = addrPtr_q;
      error_d    = 1'b1;
    end

    muxSel_d = 2'b00;
    inj_d    = 8'h00;
    arLoad_d = 1'b0;
    cs_d     = 1'b0;
    we_d     = 1'b0;
    done_d   = 1'b0;
    case (state_d)
      LOAD_ADDR: begin
        muxSel_d = 2'b10;
        inj_d    = opAddr_d;
        arLoad_d = 1'b1;
      end
      SETTLE: begin
        muxSel_d = 2'b10;
        inj_d    = opAddr_d;
      end
      WRITE: begin
        muxSel_d = 2'b01;
        inj_d    = opData_d;
        cs_d     = 1'b1;
        we_d     = 1'b1;
      end
      READ: begin
        cs_d = 1'b1;
      end
      FINISH: begin
        done_d = 1'b1;
      end
      default: begin
        muxSel_d = 2'b00;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Edge registers track the command levels even in reset, so a held switch never fires.
  always_ff @(posedge clk) begin
    depPrev_q <= bus.cmd_deposit;
    exaPrev_q <= bus.cmd_examine;
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      opAddr_q   <= 8'h00;
      opData_q   <= 8'h00;
      isWrite_q  <= 1'b0;
      autoInc_q  <= 1'b0;
      addrPtr_q  <= 8'h00;
      examData_q <= 8'h00;
      muxSel_q   <= 2'b00;
      inj_q      <= 8'h00;
      arLoad_q   <= 1'b0;
      cs_q       <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opAddr_q   <= opAddr_d;
      opData_q   <= opData_d;
      isWrite_q  <= isWrite_d;
      autoInc_q  <= autoInc_d;
      addrPtr_q  <= addrPtr_d;
      examData_q <= examData_d;
      muxSel_q   <= muxSel_d;
      inj_q      <= inj_d;
      arLoad_q   <= arLoad_d;
      cs_q       <= cs_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign bus.mux_select         = muxSel_q;
  assign bus.data_bus_injection = inj_q;
  assign bus.ar_load            = arLoad_q;
  assign bus.memory_cs          = cs_q;
  assign bus.memory_we          = we_q;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
  assign bus.error              = error_q;
  assign bus.examine_data       = examData_q;
  assign bus.addr_ptr           = addrPtr_q;

endmodule

// File: tb/tb_panel_mem_sequencer.sv
// Directed bench for panel_mem_sequencer with a small AR + 256-byte memory model on the bus.
module tb_panel_mem_sequencer;

  logic clk;
  logic reset;
  int   vectorCount;
  int   missCount;

  panel_mem_sequencer_if pif();

  panel_mem_sequencer #(
    .SETTLE_CYCLES(1),
    .WE_CYCLES    (2),
    .READ_CYCLES  (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (pif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: address register and memory driven by the sequencer's strobes.
  logic [7:0] mem [256];
  logic [7:0] arReg;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      arReg <= 8'h00;
    end else begin
      if (pif.ar_load) arReg <= pif.data_bus_injection;
      if (pif.memory_cs && pif.memory_we) mem[arReg] <= pif.data_bus_injection;
    end
  end

  assign pif.data_bus = (pif.memory_cs && !pif.memory_we) ? mem[arReg] :
                        (pif.mux_select != 2'b00) ? pif.data_bus_injection : 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic autoInc, input logic [7:0] addr, input logic [7:0] data);
    pif.cmd_auto_inc = autoInc;
    pif.panel_addr   = addr;
    pif.panel_data   = data;
  endtask

  // {busy, mux, inj, ar_load, cs, we, done, error}
  function automatic logic [15:0] packOut();
    return {pif.busy, pif.mux_select, pif.data_bus_injection, pif.ar_load,
            pif.memory_cs, pif.memory_we, pif.done, pif.error};
  endfunction

  // Fire command edges for one cycle, then watch a fixed window and tally activity.
  task automatic runOp(input logic dep, input logic exa,
                       output int busyN, output int arN, output int csN, output int weN,
                       output int doneN, output int errN, output int badN);
    busyN = 0; arN = 0; csN = 0; weN = 0; doneN = 0; errN = 0; badN = 0;
    pif.cmd_deposit = dep;
    pif.cmd_examine = exa;
    for (int i = 0; i < 12; i++) begin
      tick();
      pif.cmd_deposit = 1'b0;
      pif.cmd_examine = 1'b0;
      if (pif.busy)      busyN++;
      if (pif.ar_load)   arN++;
      if (pif.memory_cs) csN++;
      if (pif.memory_we) weN++;
      if (pif.done)      doneN++;
      if (pif.error)     errN++;
      if (pif.memory_we && !pif.memory_cs) badN++;
      if (pif.memory_cs && (pif.ar_load || pif.mux_select == 2'b10)) badN++;
    end
  endtask

  initial begin
    logic [15:0] expTrace [6];
    int busyN, arN, csN, weN, doneN, errN, badN;
    vectorCount = 0;
    missCount   = 0;

    reset = 1'b1;
    pif.cpu_halted  = 1'b1;
    pif.cmd_deposit = 1'b0;
    pif.cmd_examine = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00);
    tick(3);
    reset = 1'b0;
    tick();
    checkOutput("reset_outputs", {16'h0, packOut()}, 32'h0);
    checkOutput("reset_ptr_exam", {16'h0, pif.addr_ptr, pif.examine_data}, 32'h0);

    // Deposit 0xA5 at 0x3C, traced cycle by cycle
    expTrace[0] = {1'b1, 2'b10, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    expTrace[1] = {1'b1, 2'b10, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    expTrace[2] = {1'b1, 2'b01, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    expTrace[3] = {1'b1, 2'b01, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    expTrace[4] = {1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    expTrace[5] = 16'h0000;
    applyStimulus(1'b0, 8'h3C, 8'hA5);
    pif.cmd_deposit = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      pif.cmd_deposit = 1'b0;
      checkOutput($sformatf("dep_trace_%0d", i), {16'h0, packOut()}, {16'h0, expTrace[i]});
    end
    checkOutput("dep_mem_3C", {24'h0, mem[8'h3C]}, 32'hA5);
    checkOutput("dep_ptr", {24'h0, pif.addr_ptr}, 32'h3C);

    // Examine 0x3C
    applyStimulus(1'b0, 8'h3C, 8'h00);
    runOp(1'b0, 1'b1, busyN, arN, csN, weN, doneN, errN, badN);
    checkOutput("exa_busy", busyN, 5);
    checkOutput("exa_cs_we", {csN[15:0], weN[15:0]}, {16'd2, 16'd0});
    checkOutput("exa_done_err", {doneN[15:0], errN[15:0]}, {16'd1, 16'd0});
    checkOutput("exa_data", {24'h0, pif.examine_data}, 32'hA5);
    checkOutput("exa_strobe_rules", badN, 0);

    // Auto-increment across the FF->00 wrap
    applyStimulus(1'b0, 8'hFF, 8'h00);
    runOp(1'b0, 1'b1, busyN, arN, csN, weN, doneN, errN, badN);
    checkOutput("ptr_load_FF", {24'h0, pif.addr_ptr}, 32'hFF);
    applyStimulus(1'b1, 8'h55, 8'h11);
    runOp(1'b1, 1'b0, busyN, arN, csN, weN, doneN, errN, badN);
    checkOutput("inc_mem_FF", {24'h0, mem[8'hFF]}, 32'h11);
    checkOutput("inc_mem_55", {24'h0, mem[8'h55]}, 32'h00);
    checkOutput("inc_ptr_wrap", {24'h0, pif.addr_ptr}, 32'h00);
    checkOutput("inc_dep_busy_we", {busyN[15:0], weN[15:0]}, {16'd5, 16'd2});
    applyStimulus(1'b1, 8'h55, 8'h22);
    runOp(1'b1, 1'b0, busyN, arN, csN, weN, doneN, errN, badN);
    checkOutput("inc_mem_00", {24'h0, mem[8'h00]}, 32'h22);
    checkOutput("inc_ptr_01", {24'h0, pif.addr_ptr}, 32'h01);

    // Command while CPU running is rejected
    pif.cpu_halted = 1'b0;
    applyStimulus(1'b0, 8'h20, 8'h33);
    pif.cmd_deposit = 1'b1;
    tick();
    pif.cmd_deposit = 1'b0;
    checkOutput("run_reject", {16'h0, packOut()}, 32'h0001);
    tick();
    checkOutput("run_reject_after", {16'h0, packOut()}, 32'h0);
    checkOutput("run_reject_mem", {24'h0, mem[8'h20]}, 32'h00);
    pif.cpu_halted = 1'b1;
    tick();

    // Halt lost during first WRITE cycle
    applyStimulus(1'b0, 8'h40, 8'h77);
    pif.cmd_deposit = 1'b1;
    tick();
    pif.cmd_deposit = 1'b0;
    tick(2);
    checkOutput("abort_in_write", {30'h0, pif.memory_cs, pif.memory_we}, 32'h3);
    pif.cpu_halted = 1'b0;
    tick();
    checkOutput("abort_outputs", {16'h0, packOut()}, 32'h0001);
    checkOutput("abort_ptr", {24'h0, pif.addr_ptr}, 32'h40);
    tick();
    checkOutput("abort_no_done", {30'h0, pif.done, pif.error}, 32'h0);
    pif.cpu_halted = 1'b1;
    tick();

    // Simultaneous edges: deposit wins
    applyStimulus(1'b0, 8'h60, 8'h99);
    runOp(1'b1, 1'b1, busyN, arN, csN, weN, doneN, errN, badN);
    checkOutput("both_we", {arN[15:0], weN[15:0]}, {16'd1, 16'd2});
    checkOutput("both_mem_60", {24'h0, mem[8'h60]}, 32'h99);
    checkOutput("both_done", doneN, 1);

    // Deposit held high across reset release
    pif.cmd_deposit = 1'b1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    busyN = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pif.busy || pif.ar_load || pif.error) busyN++;
    end
    checkOutput("held_through_reset", busyN, 0);
    pif.cmd_deposit = 1'b0;
    tick();

    // Reset mid-READ clears everything
    applyStimulus(1'b0, 8'h10, 8'h5A);
    runOp(1'b1, 1'b0, busyN, arN, csN, weN, doneN, errN, badN);
    runOp(1'b0, 1'b1, busyN, arN, csN, weN, doneN, errN, badN);
    checkOutput("pre_reset_exam", {24'h0, pif.examine_data}, 32'h5A);
    pif.cmd_examine = 1'b1;
    tick();
    pif.cmd_examine = 1'b0;
    tick(2);
    checkOutput("in_read", {30'h0, pif.memory_cs, pif.memory_we}, 32'h2);
    reset = 1'b1;
    tick();
    checkOutput("reset_mid_read", {packOut(), pif.examine_data, pif.addr_ptr}, 32'h0);
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
